intt_pe: RTL and testbench

INTT_PE -- requirements
Module: intt_pe

---
 rtl/intt_pe_if.sv | 37 +++
 rtl/intt_pe.sv | 113 +++++++++++
 tb/tb_intt_pe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intt_pe_if.sv
`default_nettype none
// ============================================================================
//  Module      : intt_pe_if
//  Description : Streaming handshake bundle for the inverse-NTT butterfly.
//                The input beat and the result beat each use valid/ready.
//                The master side drives beats in; the slave side is the PE.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

interface intt_pe_if #(
   parameter int W = `DATA_SIZE_ARB
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_top_i;
   logic [W-1:0] data_bot_i;
   logic [W-1:0] twiddle_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] intt_top_o;
   logic [W-1:0] intt_bot_o;

   modport master (
      output in_valid, data_top_i, data_bot_i, twiddle_i, out_ready,
      input  in_ready, out_valid, intt_top_o, intt_bot_o
   );

   modport slave (
      input  in_valid, data_top_i, data_bot_i, twiddle_i, out_ready,
      output in_ready, out_valid, intt_top_o, intt_bot_o
   );
endinterface

`default_nettype wire

// File: rtl/intt_pe.sv
`default_nettype none
// ============================================================================
//  Module      : intt_pe
//  Description : Four-stage Gentleman-Sande inverse butterfly.
//                top = (a+b) mod q, bot = ((a-b) mod q)*w mod q, each result
//                optionally multiplied by 2^-1 mod q. Barrett reduction is
//                used for the product. The whole pipe stalls as one unit when
//                the output beat is held by downstream.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module intt_pe #(
   parameter int W = `DATA_SIZE_ARB
) (
   input  wire logic           clk,
   input  wire logic           reset,     // asynchronous, active low
   input  wire logic [W-1:0]   q,
   // floor(2^(2W)/q) exceeds W+1 bits for any q below 2^(W-1), so the
   // constant is carried at full 2W width to keep the estimate exact.
   input  wire logic [2*W-1:0] mu,
   input  wire logic           halve_en,
   intt_pe_if.slave            bus,
   output logic                busy
);

   // Multiply by 2^-1 mod q: an odd value borrows q to become even first.
   function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x,
                                              input logic [W-1:0] m);
      logic [W:0] t;
      t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return W'(t >> 1);
   endfunction

   logic           advance;
   logic           v1, v2, v3, v4;
   logic [W-1:0]   top1, d1, w1;
   logic [W-1:0]   top2;
   logic [2*W-1:0] p2;
   logic [W-1:0]   top3, qest3;
   logic [2*W-1:0] p3;
   logic [W-1:0]   out_top, out_bot;

   logic [W:0]     sum_raw;
   logic [W-1:0]   sum_mod, diff_mod;
   logic [2*W-1:0] prod;
   logic [W-1:0]   qest;
   logic [W+1:0]   r0, r1, r2;
   logic [W-1:0]   top_fin, bot_fin;

   assign advance      = !v4 || bus.out_ready;
   assign bus.in_ready = advance;
   assign bus.out_valid  = v4;
   assign bus.intt_top_o = out_top;
   assign bus.intt_bot_o = out_bot;
   assign busy = v1 || v2 || v3 || v4;

   // S1 arithmetic: modular add and subtract, one correction each.
   always_comb begin
      sum_raw = {1'b0, bus.data_top_i} + {1'b0, bus.data_bot_i};
      sum_mod = (sum_raw >= {1'b0, q}) ? W'(sum_raw - {1'b0, q}) : W'(sum_raw);
      if (bus.data_top_i >= bus.data_bot_i)
         diff_mod = bus.data_top_i - bus.data_bot_i;
      else
         diff_mod = W'({1'b0, bus.data_top_i} + {1'b0, q} - {1'b0, bus.data_bot_i});
   end

   // S2/S3 arithmetic: full product, then Barrett quotient estimate (low by at most 2).
   always_comb begin
      prod = {{W{1'b0}}, d1} * {{W{1'b0}}, w1};
      qest = W'(({{(2*W){1'b0}}, p2} * {{(2*W){1'b0}}, mu}) >> (2*W));
   end

   // S4 arithmetic: remainder below 3q, two corrective subtractions, optional halving.
   always_comb begin
      r0 = (W+2)'(p3 - ({{W{1'b0}}, qest3} * {{W{1'b0}}, q}));
      r1 = (r0 >= {2'b00, q}) ? (r0 - {2'b00, q}) : r0;
      r2 = (r1 >= {2'b00, q}) ? (r1 - {2'b00, q}) : r1;
      top_fin = halve_en ? halve_mod(top3, q) : top3;
      bot_fin = halve_en ? halve_mod(W'(r2), q) : W'(r2);
   end

   // Pipeline registers: all stages move together on advance, hold otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
         top1 <= '0; d1 <= '0; w1 <= '0;
         top2 <= '0; p2 <= '0;
         top3 <= '0; qest3 <= '0; p3 <= '0;
         out_top <= '0; out_bot <= '0;
      end else if (advance) begin
         v1      <= bus.in_valid;
         top1    <= sum_mod;
         d1      <= diff_mod;
         w1      <= bus.twiddle_i;
         v2      <= v1;
         top2    <= top1;
         p2      <= prod;
         v3      <= v2;
         top3    <= top2;
         p3      <= p2;
         qest3   <= qest;
         v4      <= v3;
         out_top <= top_fin;
         out_bot <= bot_fin;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_intt_pe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intt_pe
//  Description : Self-checking bench for intt_pe with a modular-arithmetic
//                reference model and a per-cycle output comparator.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps

module tb_intt_pe;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   q;
   logic [2*W-1:0] mu;
   logic           halve_en;
   logic           busy;

   intt_pe_if #(.W(W)) bus ();

   intt_pe #(.W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .q        (q),
      .mu       (mu),
      .halve_en (halve_en),
      .bus      (bus.slave),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     fails  = 0;
   int     delivered = 0;
   int     outstanding = 0;
   longint exp_t_q[$];
   longint exp_b_q[$];
   bit     stall_pending = 1'b0;
   longint held_top, held_bot;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain modular arithmetic; halving is multiplication by (q+1)/2.
   function automatic void model(input longint qq, input longint a, input longint b,
                                 input longint w, input bit h,
                                 output longint t, output longint bo);
      longint inv2;
      t  = (a + b) % qq;
      bo = ((((a - b) % qq) + qq) % qq * w) % qq;
      if (h) begin
         inv2 = (qq + 1) / 2;
         t  = (t * inv2) % qq;
         bo = (bo * inv2) % qq;
      end
   endfunction

   // Comparator: every negedge, account handshakes that the next posedge will take.
   always @(negedge clk) begin
      longint et, eb;
      if (!reset) begin
         exp_t_q.delete();
         exp_b_q.delete();
         outstanding   = 0;
         stall_pending = 1'b0;
      end else begin
         check("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready));
         check("busy_vs_outstanding", busy, (outstanding != 0));
         if (stall_pending) begin
            check("stall_valid_held", bus.out_valid, 1);
            check("stall_top_held", bus.intt_top_o, held_top);
            check("stall_bot_held", bus.intt_bot_o, held_bot);
         end
         if (bus.out_valid) begin
            check("top_reduced", (bus.intt_top_o < q), 1);
            check("bot_reduced", (bus.intt_bot_o < q), 1);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("result_expected", (exp_t_q.size() > 0), 1);
            if (exp_t_q.size() > 0) begin
               et = exp_t_q.pop_front();
               eb = exp_b_q.pop_front();
               check("out_top", bus.intt_top_o, et);
               check("out_bot", bus.intt_bot_o, eb);
            end
            delivered++;
            outstanding--;
         end
         stall_pending = bus.out_valid && !bus.out_ready;
         held_top = bus.intt_top_o;
         held_bot = bus.intt_bot_o;
         if (bus.in_valid && bus.in_ready) begin
            model(q, bus.data_top_i, bus.data_bot_i, bus.twiddle_i, halve_en, et, eb);
            exp_t_q.push_back(et);
            exp_b_q.push_back(eb);
            outstanding++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int unsigned qq, input bit h);
      q        = W'(qq);
      mu       = (2*W)'((64'd1 << (2*W)) / 64'(qq));
      halve_en = h;
   endtask

   task automatic wait_idle();
      int n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   // One beat on an empty pipe: out_valid must rise exactly on the 4th edge.
   task automatic directed(input string name, input int unsigned a, input int unsigned b,
                           input int unsigned w, input longint et, input longint eb);
      wait_idle();
      bus.data_top_i = W'(a);
      bus.data_bot_i = W'(b);
      bus.twiddle_i  = W'(w);
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 1; k < 4; k++) begin
         check({name, "_latency_low"}, bus.out_valid, 0);
         tick();
      end
      check({name, "_latency_valid"}, bus.out_valid, 1);
      check({name, "_top"}, bus.intt_top_o, et);
      check({name, "_bot"}, bus.intt_bot_o, eb);
      tick();
   endtask

   task automatic random_round(input int unsigned qq, input bit h);
      int acc = 0;
      int cyc = 0;
      int start;
      wait_idle();
      set_cfg(qq, h);
      start = delivered;
      while (acc < 16 && cyc < 2000) begin
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.data_top_i = W'($urandom_range(0, qq - 1));
         bus.data_bot_i = W'($urandom_range(0, qq - 1));
         bus.twiddle_i  = W'($urandom_range(0, qq - 1));
         bus.out_ready  = $urandom_range(0, 1) != 0;
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc++;
         tick();
         cyc++;
      end
      wait_idle();
      check("random_beat_count", delivered - start, 16);
   endtask

   task automatic corner_sweep(input int unsigned qq, input bit h);
      int unsigned cv[3];
      int start;
      wait_idle();
      set_cfg(qq, h);
      cv[0] = 0; cv[1] = 1; cv[2] = qq - 1;
      start = delivered;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++) begin
               bus.data_top_i = W'(cv[i]);
               bus.data_bot_i = W'(cv[j]);
               bus.twiddle_i  = W'(cv[k]);
               bus.in_valid   = 1'b1;
               tick();
            end
      wait_idle();
      check("corner_beat_count", delivered - start, 27);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint mt, mb;
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.data_top_i = '0;
      bus.data_bot_i = '0;
      bus.twiddle_i = '0;
      set_cfg(7681, 1'b0);

      // Reset values while held.
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_top", bus.intt_top_o, 0);
      check("rst_bot", bus.intt_bot_o, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      tick();
      check("post_rst_in_ready", bus.in_ready, 1);

      // Pin the reference model against hand-computed values.
      model(7681, 3046, 2769, 1853, 1'b0, mt, mb);
      check("model_top", mt, 5815);
      check("model_bot", mb, 6335);
      model(7681, 3046, 2769, 1853, 1'b1, mt, mb);
      check("model_half_top", mt, 6748);
      check("model_half_bot", mb, 7008);

      // Known vectors with literal expectations and latency.
      directed("vec", 3046, 2769, 1853, 5815, 6335);
      set_cfg(7681, 1'b1);
      directed("vec_half", 3046, 2769, 1853, 6748, 7008);
      set_cfg(7681, 1'b0);
      directed("wrap_lo", 0, 1, 1, 1, 7680);
      directed("wrap_hi", 7680, 7680, 7680, 7679, 0);

      // Random streams with pseudo-random backpressure.
      random_round(7681, 1'b0);
      random_round(12289, 1'b1);

      // Corner sweep over {0,1,q-1}.
      corner_sweep(7681, 1'b0);
      corner_sweep(7681, 1'b1);
      corner_sweep(12289, 1'b0);
      corner_sweep(12289, 1'b1);

      // Reset with three beats in flight.
      wait_idle();
      set_cfg(7681, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.data_top_i = W'(100 + i);
         bus.data_bot_i = W'(7 * i);
         bus.twiddle_i  = W'(55 + i);
         bus.in_valid   = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      check("inflight_busy", busy, 1);
      #2 reset = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_top", bus.intt_top_o, 0);
      check("midrst_bot", bus.intt_bot_o, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("no_stale_out", bus.out_valid, 0);
      end
      directed("after_rst", 3046, 2769, 1853, 5815, 6335);

      wait_idle();
      check("final_queue_empty", exp_t_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
